mpmc11_wdf_burst_seq: RTL and testbench
=======================================

Name: mpmc11_wdf_burst_seq

Overview:
- Write-data burst sequencer between the mpmc11 controller state machine and the MIG UI write-data channel.
- Successor of the single-compare write-end generator.
- Accepts a burst request, pulls write beats from a valid/ready source, and drives app_wdf_wren/data/mask/end with correct end framing for 2:1 or 4:1 PHY clock ratios.
- Absorbs app_wdf_rdy back-pressure and reports completion.

Parameters:
- DATA_WIDTH, 128, width of one UI write beat (app_wdf_data).
- CLK_RATIO, 4, PHY:UI clock ratio; 4 means 1 beat per DRAM burst, 2 means 2 beats per DRAM burst; any other value is illegal (elaboration $error).
- LEN_WIDTH, 8, width of burst_len; the request covers burst_len+1 DRAM bursts.

Ports:
- clk  input  1  UI clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- burst_len  input  LEN_WIDTH  DRAM bursts minus one; latched on accepted start.
- s_valid  input  1  source beat valid.
- s_ready  output  1  sequencer accepts the source beat this cycle.
- s_data  input  DATA_WIDTH  source beat data.
- s_mask  input  DATA_WIDTH/8  source byte mask (1 = do not write).
- app_wdf_rdy  input  1  MIG write FIFO ready.
- app_wdf_wren  output  1  beat valid to MIG.
- app_wdf_data  output  DATA_WIDTH  registered beat data.
- app_wdf_mask  output  DATA_WIDTH/8  registered beat mask.
- app_wdf_end  output  1  last beat of a DRAM burst.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when the final beat is taken by MIG.
- start_err  output  1  one-cycle pulse when start arrives while busy.
- burst_cnt  output  LEN_WIDTH  DRAM bursts completed in the current request.

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs 0, all counters 0, output register empty. Reset mid-burst abandons the burst with no done pulse; partially sent beats are the controller's problem.
- Constants:
  - BPB = (CLK_RATIO==4) ? 1 : 2 beats per DRAM burst.
  - TOT = (burst_len+1)*BPB beats, computed at start.
  - Beat counters are LEN_WIDTH+2 bits wide (max 512 beats at default) so they never wrap.
- States:
  - IDLE: on start, latch len, clear acc_cnt, sent_cnt, beat, burst_cnt, then go to DATA. start in any other state is ignored and pulses start_err for one cycle.
  - DATA: streams beats. When the final beat transfers, go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- Output register: single entry, out_v.
  - app_wdf_wren = out_v.
  - xfer = out_v && app_wdf_rdy.
- s_ready = (state==DATA) && (acc_cnt < TOT) && (!out_v || app_wdf_rdy). No over-fetch past TOT, ever.
- Accept = s_valid && s_ready:
  - load data and mask;
  - out_v stays 1;
  - acc_cnt++.
- xfer without accept: out_v clears.
- Simultaneous xfer and accept: out_v stays set and new data loads with zero bubble, sustaining 1 beat/cycle.
- app_wdf_end = out_v && (beat == BPB-1). It is combinational from registered state; app_wdf_end never rises without app_wdf_wren.
- On xfer:
  - sent_cnt++;
  - beat = (beat==BPB-1) ? 0 : beat+1;
  - burst_cnt increments when end is transferred.
  - If sent_cnt+1 == TOT, next state is DONE.
- Data, mask, wren and end hold stable while app_wdf_rdy=0 (MIG UI rule).
- Latency: a source beat accepted in cycle n is on app_wdf_* in cycle n+1.
- burst_cnt holds its final value (len+1) after DONE until the next start.
- burst_len=0 with CLK_RATIO=4 gives a single beat, with wren and end together, then done.

Decomposition:
- Package mpmc11_pkg gains typedef mpmc11_wdf_state_t {WDF_IDLE, WDF_DATA, WDF_DONE}.
- mpmc11_pkg also gains localparam function wdf_beats_per_burst(ratio).
- Natural sub-module: mpmc11_wdf_skid, the one-entry output register with valid/ready pass-through, parametrised on DATA_WIDTH.
- The sequencer FSM and counters stay in mpmc11_wdf_burst_seq.

Test Plan:
- CLK_RATIO=4, burst_len=3, s_valid and app_wdf_rdy held 1 -> 4 consecutive wren cycles, end=1 on each; done 1 cycle after the 4th beat; burst_cnt=4.
- CLK_RATIO=2, burst_len=1, data 0x11..0x44 -> 4 beats in order; end on beats 2 and 4 only; burst_cnt steps 0,1,2.
- CLK_RATIO=2, burst_len=0, app_wdf_rdy low for 3 cycles on beat 1 -> wren/data/end stay frozen; s_ready=0 while stalled; exactly 2 beats total; no extra s_ready after 2 accepts.
- Random s_valid gaps and app_wdf_rdy toggling (CLK_RATIO=4, burst_len=7) -> 8 beats, in order, no duplicates or drops; done once.
- start asserted during DATA -> start_err pulse; len unchanged; burst completes normally.
- rst_n dropped mid-burst (after 2 of 8 beats) -> all outputs 0 asynchronously; no done; a new start after release runs a clean 8-beat burst.

Source files
------------

// File: rtl/mpmc11_pkg.sv
// ---------------------------------------------------------------------------
// mpmc11_pkg
// Shared types and helpers for the mpmc11 memory controller slice.
//   mpmc11_wdf_state_t  : write-data burst sequencer states
//   wdf_beats_per_burst : UI beats per DRAM burst for a PHY:UI clock ratio
// ---------------------------------------------------------------------------
package mpmc11_pkg;

    typedef enum logic [1:0] {
        WDF_IDLE = 2'd0,
        WDF_DATA = 2'd1,
        WDF_DONE = 2'd2
    } mpmc11_wdf_state_t;

    // 4:1 moves a whole BL8 burst in one UI beat, 2:1 needs two.
    function automatic int wdf_beats_per_burst(input int ratio);
        return (ratio == 4) ? 1 : 2;
    endfunction

endpackage

// File: rtl/mpmc11_wdf_skid.sv
// ---------------------------------------------------------------------------
// mpmc11_wdf_skid
// One-entry output register for the MIG write-data channel. The parent only
// raises i_load when the entry is empty or is being drained this cycle, so a
// load and a drain in the same cycle keep the entry full (zero bubble).
// Ports:
//   clk, rst_n : UI clock, async active-low reset
//   i_load     : capture i_data/i_mask this cycle
//   i_data     : beat data          i_mask : beat byte mask
//   i_rdy      : downstream ready (app_wdf_rdy)
//   o_valid    : entry full (drives app_wdf_wren)
//   o_data     : registered data    o_mask : registered mask
// ---------------------------------------------------------------------------
module mpmc11_wdf_skid #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [DATA_WIDTH/8-1:0] i_mask,
    input  logic                    i_rdy,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_mask
);

    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH/8-1:0] r_mask;

    // Data and mask only change on a load, so they stay frozen while the
    // MIG holds app_wdf_rdy low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_mask  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_mask  <= i_mask;
        end else if (r_valid && i_rdy) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_mask  = r_mask;

endmodule

// File: rtl/mpmc11_wdf_burst_seq.sv
// ---------------------------------------------------------------------------
// mpmc11_wdf_burst_seq
// Write-data burst sequencer between the mpmc11 controller FSM and the MIG
// UI write-data channel. Pulls (burst_len+1) DRAM bursts worth of beats from
// a valid/ready source and frames app_wdf_end for 2:1 or 4:1 clock ratios.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   WDF_IDLE | waiting for start; length latched on accept
//   WDF_DATA | fetching source beats and draining them to the MIG
//   WDF_DONE | final beat taken; done is high for this one cycle
//
// Ports:
//   clk, rst_n           : UI clock, async active-low reset
//   start, burst_len     : request pulse and DRAM bursts minus one
//   s_valid/s_ready      : source handshake, s_data/s_mask beat payload
//   app_wdf_rdy          : MIG write FIFO ready
//   app_wdf_wren/data/mask/end : MIG write-data channel
//   busy, done, start_err, burst_cnt : status to the controller
// ---------------------------------------------------------------------------
module mpmc11_wdf_burst_seq
    import mpmc11_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int CLK_RATIO  = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [DATA_WIDTH/8-1:0] s_mask,
    input  logic                    app_wdf_rdy,
    output logic                    app_wdf_wren,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_end,
    output logic                    busy,
    output logic                    done,
    output logic                    start_err,
    output logic [LEN_WIDTH-1:0]    burst_cnt
);

    if (CLK_RATIO != 2 && CLK_RATIO != 4) begin : g_bad_ratio
        $error("mpmc11_wdf_burst_seq: CLK_RATIO must be 2 or 4");
    end

    localparam int BPB = wdf_beats_per_burst(CLK_RATIO);
    // Two extra bits hold (2^LEN_WIDTH)*2 beats without wrapping.
    localparam int CW  = LEN_WIDTH + 2;

    mpmc11_wdf_state_t      r_state;
    logic [CW-1:0]          r_tot;
    logic [CW-1:0]          r_acc_cnt;
    logic [CW-1:0]          r_sent_cnt;
    logic                   r_beat;
    logic [LEN_WIDTH-1:0]   r_burst_cnt;
    logic                   r_done;
    logic                   r_start_err;

    logic                   w_out_v;
    logic                   w_xfer;
    logic                   w_accept;
    logic                   w_s_ready;
    logic                   w_last_beat;
    logic [CW-1:0]          w_tot_start;

    assign w_tot_start = ({2'b00, burst_len} + CW'(1)) * CW'(BPB);
    assign w_last_beat = (r_beat == 1'(BPB - 1));

    // Never fetch past the request total, and only when the output register
    // is empty or draining this cycle.
    assign w_s_ready = (r_state == WDF_DATA) && (r_acc_cnt < r_tot)
                       && (!w_out_v || app_wdf_rdy);
    assign w_accept  = s_valid && w_s_ready;
    assign w_xfer    = w_out_v && app_wdf_rdy;

    mpmc11_wdf_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_data  (s_data),
        .i_mask  (s_mask),
        .i_rdy   (app_wdf_rdy),
        .o_valid (w_out_v),
        .o_data  (app_wdf_data),
        .o_mask  (app_wdf_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WDF_IDLE;
            r_tot       <= '0;
            r_acc_cnt   <= '0;
            r_sent_cnt  <= '0;
            r_beat      <= 1'b0;
            r_burst_cnt <= '0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_start_err <= start && (r_state != WDF_IDLE);
            case (r_state)
                WDF_IDLE: begin
                    if (start) begin
                        r_tot       <= w_tot_start;
                        r_acc_cnt   <= '0;
                        r_sent_cnt  <= '0;
                        r_beat      <= 1'b0;
                        r_burst_cnt <= '0;
                        r_state     <= WDF_DATA;
                    end
                end
                WDF_DATA: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + CW'(1);
                    end
                    if (w_xfer) begin
                        r_sent_cnt <= r_sent_cnt + CW'(1);
                        r_beat     <= w_last_beat ? 1'b0 : (r_beat + 1'b1);
                        if (w_last_beat) begin
                            r_burst_cnt <= r_burst_cnt + LEN_WIDTH'(1);
                        end
                        // done is raised together with the DONE state so it
                        // is high for exactly the one cycle spent there.
                        if (r_sent_cnt + CW'(1) == r_tot) begin
                            r_state <= WDF_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                WDF_DONE: begin
                    r_state <= WDF_IDLE;
                end
                default: begin
                    r_state <= WDF_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = w_s_ready;
    assign app_wdf_wren = w_out_v;
    assign app_wdf_end  = w_out_v && w_last_beat;
    assign busy         = (r_state != WDF_IDLE);
    assign done         = r_done;
    assign start_err    = r_start_err;
    assign burst_cnt    = r_burst_cnt;

endmodule

// File: tb/tb_mpmc11_wdf_burst_seq.sv
// ---------------------------------------------------------------------------
// tb_mpmc11_wdf_burst_seq
// Two instances (CLK_RATIO=4 and CLK_RATIO=2) share the source and MIG-side
// inputs; each has its own start. sel picks which instance is observed.
// Expected beats are pushed when the bench sees a source beat accepted and
// popped when the observed instance hands a beat to the MIG.
// ---------------------------------------------------------------------------
module tb_mpmc11_wdf_burst_seq;

    localparam int DW = 128;
    localparam int MW = DW / 8;
    localparam int LW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        logic          e;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          start4, start2;
    logic [LW-1:0] burst_len;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [MW-1:0] s_mask;
    logic          app_wdf_rdy;

    logic          ready4, wren4, end4, busy4, done4, serr4;
    logic [DW-1:0] data4;
    logic [MW-1:0] mask4;
    logic [LW-1:0] bcnt4;
    logic          ready2, wren2, end2, busy2, done2, serr2;
    logic [DW-1:0] data2;
    logic [MW-1:0] mask2;
    logic [LW-1:0] bcnt2;

    logic          sel;
    logic          m_ready, m_wren, m_end, m_busy, m_done, m_serr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;
    logic [LW-1:0] m_bcnt;

    assign m_ready = sel ? ready2 : ready4;
    assign m_wren  = sel ? wren2  : wren4;
    assign m_end   = sel ? end2   : end4;
    assign m_busy  = sel ? busy2  : busy4;
    assign m_done  = sel ? done2  : done4;
    assign m_serr  = sel ? serr2  : serr4;
    assign m_data  = sel ? data2  : data4;
    assign m_mask  = sel ? mask2  : mask4;
    assign m_bcnt  = sel ? bcnt2  : bcnt4;

    mpmc11_wdf_burst_seq #(.DATA_WIDTH(DW), .CLK_RATIO(4), .LEN_WIDTH(LW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .burst_len(burst_len),
        .s_valid(s_valid), .s_ready(ready4), .s_data(s_data), .s_mask(s_mask),
        .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(wren4), .app_wdf_data(data4),
        .app_wdf_mask(mask4), .app_wdf_end(end4), .busy(busy4), .done(done4),
        .start_err(serr4), .burst_cnt(bcnt4)
    );

    mpmc11_wdf_burst_seq #(.DATA_WIDTH(DW), .CLK_RATIO(2), .LEN_WIDTH(LW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .burst_len(burst_len),
        .s_valid(s_valid), .s_ready(ready2), .s_data(s_data), .s_mask(s_mask),
        .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(wren2), .app_wdf_data(data2),
        .app_wdf_mask(mask2), .app_wdf_end(end2), .busy(busy2), .done(done2),
        .start_err(serr2), .burst_cnt(bcnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_pass  = 0;
    int    n_fail  = 0;
    beat_t q[$];
    int    burst_id = 0;
    int    src_idx, n_acc, n_xfer, n_done, n_over, n_bad_end;
    int    cyc = 0, first_x, last_x, done_cyc, tot_exp, bpb, len_exp;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int i);
        return {32'(burst_id), 64'hA5A5_0000_0000_0000 ^ 64'(i), 32'(32'h11 * (i + 1))};
    endfunction

    function automatic logic [MW-1:0] mk_mask(input int i);
        return MW'(i * 3 + burst_id * 16'h0101);
    endfunction

    // One UI cycle: sample #1 after the falling edge, then advance.
    task automatic cycle();
        beat_t exp;
        #1;
        if (m_ready && n_acc >= tot_exp) n_over++;
        if (s_valid && m_ready) begin
            exp.d = mk_data(src_idx);
            exp.m = mk_mask(src_idx);
            exp.e = (bpb == 2) ? ((n_acc % 2) == 1) : 1'b1;
            q.push_back(exp);
            n_acc++;
            src_idx++;
        end
        if (m_wren && app_wdf_rdy) begin
            check("bcnt_step", m_bcnt, DW'(n_xfer / bpb));
            if (q.size() == 0) begin
                check("sb_underflow", DW'(q.size()), DW'(1));
            end else begin
                exp = q.pop_front();
                check("beat_data", m_data, exp.d);
                check("beat_mask", DW'(m_mask), DW'(exp.m));
                check("beat_end", DW'(m_end), DW'(exp.e));
            end
            n_xfer++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        if (m_end && !m_wren) n_bad_end++;
        if (m_done) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        s_data = mk_data(src_idx);
        s_mask = mk_mask(src_idx);
    endtask

    task automatic new_burst(input logic s, input int len);
        sel = s;
        q.delete();
        burst_id++;
        src_idx = 0; n_acc = 0; n_xfer = 0; n_done = 0; n_over = 0; n_bad_end = 0;
        first_x = -1; last_x = -1; done_cyc = -1;
        bpb = s ? 2 : 1;
        len_exp = len;
        tot_exp = (len + 1) * bpb;
        s_data = mk_data(0);
        s_mask = mk_mask(0);
        burst_len = LW'(len);
        if (s) start2 = 1'b1; else start4 = 1'b1;
        cycle();
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic finish_burst(input int vpct, input int rpct, input int max_cyc);
        int i = 0;
        while (n_done == 0 && i < max_cyc) begin
            s_valid     = ($urandom_range(0, 99) < vpct);
            app_wdf_rdy = ($urandom_range(0, 99) < rpct);
            cycle();
            i++;
        end
        s_valid = 1'b1;
        app_wdf_rdy = 1'b1;
        cycle();
        cycle();
        s_valid = 1'b0;
        check("done_once", DW'(n_done), DW'(1));
        check("beats_sent", DW'(n_xfer), DW'(tot_exp));
        check("beats_fetched", DW'(n_acc), DW'(tot_exp));
        check("no_overfetch", DW'(n_over), DW'(0));
        check("sb_drained", DW'(q.size()), DW'(0));
        check("end_without_wren", DW'(n_bad_end), DW'(0));
        check("burst_cnt_final", DW'(m_bcnt), DW'(len_exp + 1));
        check("idle_after", DW'(m_busy), DW'(0));
    endtask

    task automatic check_reset_outputs();
        check("rst4_ctl", DW'({ready4, wren4, end4, busy4, done4, serr4, bcnt4, mask4}), DW'(0));
        check("rst4_data", data4, '0);
        check("rst2_ctl", DW'({ready2, wren2, end2, busy2, done2, serr2, bcnt2, mask2}), DW'(0));
        check("rst2_data", data2, '0);
    endtask

    initial begin
        logic [DW-1:0] held_data;
        int            guard;
        rst_n = 1'b0; start4 = 1'b0; start2 = 1'b0; burst_len = '0;
        s_valid = 1'b0; s_data = '0; s_mask = '0; app_wdf_rdy = 1'b0; sel = 1'b0;
        bpb = 1; tot_exp = 0; n_acc = 0; n_xfer = 0; src_idx = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ratio 4, len 3, no gaps: four back-to-back beats, done right after.
        new_burst(1'b0, 3);
        finish_burst(100, 100, 100);
        check("r4_burst_span", DW'(last_x - first_x), DW'(3));
        check("r4_done_latency", DW'(done_cyc - last_x), DW'(1));

        // Ratio 2, len 1: end on beats 2 and 4 (scoreboard), burst_cnt 0,1,2.
        new_burst(1'b1, 1);
        finish_burst(100, 100, 100);

        // Ratio 2, len 0, MIG stalls three cycles on the first beat.
        new_burst(1'b1, 0);
        s_valid = 1'b1;
        app_wdf_rdy = 1'b0;
        cycle();
        held_data = m_data;
        check("stall_first_data", held_data, mk_data(0));
        for (int k = 0; k < 3; k++) begin
            check("stall_wren", DW'(m_wren), DW'(1));
            check("stall_data", m_data, held_data);
            check("stall_end", DW'(m_end), DW'(0));
            #1;
            check("stall_s_ready", DW'(m_ready), DW'(0));
            @(negedge clk);
            cyc++;
        end
        finish_burst(100, 100, 100);

        // Ratio 4, len 7, random source gaps and MIG back-pressure.
        new_burst(1'b0, 7);
        finish_burst(60, 60, 1000);

        // start while busy: error pulse, request length unchanged.
        new_burst(1'b0, 7);
        s_valid = 1'b1;
        app_wdf_rdy = 1'b1;
        cycle();
        cycle();
        start4 = 1'b1;
        burst_len = 8'd2;
        cycle();
        start4 = 1'b0;
        check("start_err_pulse", DW'(m_serr), DW'(1));
        cycle();
        check("start_err_clear", DW'(m_serr), DW'(0));
        finish_burst(100, 100, 100);

        // Async reset after two of eight beats: outputs clear, no done.
        new_burst(1'b0, 7);
        s_valid = 1'b1;
        app_wdf_rdy = 1'b1;
        guard = 0;
        while (n_xfer < 2 && guard < 50) begin
            cycle();
            guard++;
        end
        check("pre_reset_beats", DW'(n_xfer), DW'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        cycle();
        cycle();
        check("no_done_on_reset", DW'(n_done), DW'(0));
        rst_n = 1'b1;
        s_valid = 1'b0;
        cycle();
        new_burst(1'b0, 7);
        finish_burst(100, 100, 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
